tenths_display: RTL

//   Downstream consumer of the 0.1 s game-clock count. Converts the 10-bit tenths count
//   (0..1023 = 0.0..102.3 s) into 4 BCD digits with a sequential shift-add-3 converter.

---
 rtl/tenths_display_pkg.sv | 50 +++++
 rtl/tenths_display_bin2bcd_seq.sv | 100 ++++++++++
 rtl/tenths_display.sv | 96 +++++++++
 3 files changed

// File: rtl/tenths_display_pkg.sv
// Shared constants for the tenths display: 7-segment patterns, converter state
// encoding and small nibble helpers.
package tenths_display_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

    // Double-dabble correction applied before each shift.
    function automatic logic [3:0] bcd_adjust(input logic [3:0] nib);
        logic [3:0] res;
        if (nib >= 4'd5) begin
            res = nib + 4'd3;
        end else begin
            res = nib;
        end
        return res;
    endfunction

endpackage

// File: rtl/tenths_display_bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter; one conversion takes
// IDLE + CNT_W shift cycles + DONE, result registered with a one-cycle valid pulse.
module bin2bcd_seq
    import tenths_display_pkg::*;
#(
    parameter int CNT_W = 10
) (
    input  logic             CLOCK10M,
    input  logic             KEY0,
    input  logic [CNT_W-1:0] bin_in,
    output logic [15:0]      bcd_out,
    output logic             bcd_valid
);

    localparam int IT_W = $clog2(CNT_W + 1);
    localparam logic [IT_W-1:0] IT_LAST = IT_W'(CNT_W - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] captured_q, captured_d;
    logic             force_q, force_d;
    logic [15:0]      scratch_q, scratch_d;
    logic [CNT_W-1:0] bin_q, bin_d;
    logic [IT_W-1:0]  iter_q, iter_d;
    logic [15:0]      bcd_q, bcd_d;
    logic             valid_q, valid_d;
    logic [15:0]      adj_s;

    // Converter next-state logic; a new count is only accepted while idle.
    always_comb begin
        state_d    = state_q;
        captured_d = captured_q;
        force_d    = force_q;
        scratch_d  = scratch_q;
        bin_d      = bin_q;
        iter_d     = iter_q;
        bcd_d      = bcd_q;
        valid_d    = 1'b0;
        adj_s      = {bcd_adjust(scratch_q[15:12]), bcd_adjust(scratch_q[11:8]),
                      bcd_adjust(scratch_q[7:4]),   bcd_adjust(scratch_q[3:0])};
        case (state_q)
            ST_IDLE: begin
                if (force_q || (bin_in != captured_q)) begin
                    captured_d = bin_in;
                    bin_d      = bin_in;
                    force_d    = 1'b0;
                    scratch_d  = 16'h0000;
                    iter_d     = {IT_W{1'b0}};
                    state_d    = ST_SHIFT;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                {scratch_d, bin_d} = {adj_s[14:0], bin_q, 1'b0};
                iter_d             = iter_q + IT_W'(1);
                if (iter_q == IT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                bcd_d   = scratch_q;
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                force_d = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Converter state registers.
    always_ff @(posedge CLOCK10M or posedge KEY0) begin
        if (KEY0) begin
            state_q    <= ST_IDLE;
            captured_q <= {CNT_W{1'b0}};
            force_q    <= 1'b1;
            scratch_q  <= 16'h0000;
            bin_q      <= {CNT_W{1'b0}};
            iter_q     <= {IT_W{1'b0}};
            bcd_q      <= 16'h0000;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            captured_q <= captured_d;
            force_q    <= force_d;
            scratch_q  <= scratch_d;
            bin_q      <= bin_d;
            iter_q     <= iter_d;
            bcd_q      <= bcd_d;
            valid_q    <= valid_d;
        end
    end

    assign bcd_out   = bcd_q;
    assign bcd_valid = valid_q;

endmodule

// File: rtl/tenths_display.sv
// Game-clock tenths count to multiplexed 4-digit 7-segment display ("DDD.D").
// Build option: LEADING_ZERO_BLANK_EN blanks leading zeros on digits 3 and 2.
module tenths_display
    import tenths_display_pkg::*;
#(
    parameter int CNT_W    = 10,
    parameter int SCAN_DIV = 10000
) (
    input  logic             CLOCK10M,
    input  logic             KEY0,
    input  logic [CNT_W-1:0] count_in,
    output logic [15:0]      bcd_out,
    output logic             bcd_valid,
    output logic [6:0]       seg_out,
    output logic             dp_out,
    output logic [3:0]       digit_sel
);

    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [1:0]       idx_q, idx_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [3:0]       sel_q, sel_d;
    logic [3:0]       nib_s;

    bin2bcd_seq #(
        .CNT_W (CNT_W)
    ) u_bin2bcd (
        .CLOCK10M  (CLOCK10M),
        .KEY0      (KEY0),
        .bin_in    (count_in),
        .bcd_out   (bcd_out),
        .bcd_valid (bcd_valid)
    );

    // Scan prescaler and digit index.
    always_comb begin
        pre_d = pre_q;
        idx_d = idx_q;
        if (pre_q == PRE_MAX) begin
            pre_d = {PRE_W{1'b0}};
            idx_d = idx_q + 2'd1;
        end else begin
            pre_d = pre_q + PRE_W'(1);
            idx_d = idx_q;
        end
    end

    // Display decode for the current slot; bcd_out is read live.
    always_comb begin
        case (idx_q)
            2'd0:    nib_s = bcd_out[3:0];
            2'd1:    nib_s = bcd_out[7:4];
            2'd2:    nib_s = bcd_out[11:8];
            2'd3:    nib_s = bcd_out[15:12];
            default: nib_s = 4'd0;
        endcase
        seg_d = seg_pattern(nib_s);
`ifdef LEADING_ZERO_BLANK_EN
        if ((idx_q == 2'd3) && (bcd_out[15:12] == 4'd0)) begin
            seg_d = SEG_BLANK;
        end else if ((idx_q == 2'd2) && (bcd_out[15:8] == 8'h00)) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = seg_pattern(nib_s);
        end
`endif
        sel_d = 4'b0001 << idx_q;
        dp_d  = (idx_q == 2'd1);
    end

    // Scan and display registers.
    always_ff @(posedge CLOCK10M or posedge KEY0) begin
        if (KEY0) begin
            pre_q <= {PRE_W{1'b0}};
            idx_q <= 2'd0;
            seg_q <= SEG_0;
            dp_q  <= 1'b0;
            sel_q <= 4'b0001;
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
            sel_q <= sel_d;
        end
    end

    assign seg_out   = seg_q;
    assign dp_out    = dp_q;
    assign digit_sel = sel_q;

endmodule
